// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path.
//   F3_*          : RV32I load/store funct3 encodings
//   lsu_state_t   : load_store_unit FSM state encoding
//   access_size() : byte count for a funct3 (size bits only)
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_t;

  // Number of bytes touched; only funct3[1:0] carries the size.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension.
//   funct3   in  3   load type (lb/lh/lw/lbu/lhu)
//   word     in  32  word captured from the data memory
//   ext_data out 32  sign- or zero-extended result
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = '0;
    case (funct3)
      F3_B:    ext_data = {{24{word[7]}}, word[7:0]};
      F3_H:    ext_data = {{16{word[15]}}, word[15:0]};
      F3_W:    ext_data = word;
      F3_BU:   ext_data = {24'b0, word[7:0]};
      F3_HU:   ext_data = {16'b0, word[15:0]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the EX/MEM register and the data memory.
//   req_*        : request from execute (valid/ready)
//   mem_*        : registered drive to the data memory, live only in ISSUE
//   mem_rdata    : memory output, captured at the end of ISSUE
//   rsp_*        : response to write-back (valid/ready)
//   busy         : pipeline stall, the inverse of req_ready
//   load_count / store_count : saturating counts of error-free accesses
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid holds its payload stable until that edge. req_ready is
// high only in IDLE, so requests presented while busy are simply ignored.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_LIMIT = 128,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  lsu_state_t       state_q, state_d;
  logic             write_q, write_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [2:0]       mem_funct3_q, mem_funct3_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;

  logic [31:0] ext_data;
  logic        f3_ok, misaligned, out_of_range, req_legal;
  logic [32:0] end_addr;

  load_extend u_load_extend (
    .funct3   (funct3_q),
    .word     (mem_rdata),
    .ext_data (ext_data)
  );

  // Legality of the request currently presented. end_addr is one past the
  // last byte touched, computed in 33 bits so it cannot wrap.
  always_comb begin
    if (req_write)
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end_addr     = {1'b0, req_addr} + 33'(access_size(req_funct3));
    out_of_range = end_addr > 33'(ADDR_LIMIT);
    req_legal    = f3_ok && !misaligned && !out_of_range;
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    // Memory drive is a one-cycle pulse: cleared unless entering ISSUE.
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_funct3_d  = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          if (req_legal) begin
            state_d      = ST_ISSUE;
            mem_read_d   = !req_write;
            mem_write_d  = req_write;
            mem_addr_d   = req_addr;
            mem_wdata_d  = req_wdata;
            mem_funct3_d = {1'b0, req_funct3[1:0]};
          end else begin
            // Rejected: skip the memory entirely.
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_d    = ST_RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = write_q ? 32'h0 : ext_data;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d    = ST_IDLE;
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          if (!rsp_err_q) begin
            if (write_q) begin
              if (store_count_q != '1) store_count_d = store_count_q + CNT_W'(1);
            end else begin
              if (load_count_q != '1) load_count_d = load_count_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_funct3_q  <= 3'b000;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_funct3_q  <= mem_funct3_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = !req_ready;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_funct3  = mem_funct3_q;
  assign load_count  = load_count_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. A second instance with 4-bit counters
// shares the stimulus so counter saturation is reached in a few stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic        req_ready, mem_read, mem_write, rsp_valid, rsp_err, busy;
  logic [31:0] mem_addr, mem_wdata, rsp_data;
  logic [2:0]  mem_funct3;
  logic [15:0] load_count, store_count;

  logic        s_req_ready, s_mem_read, s_mem_write, s_rsp_valid, s_rsp_err, s_busy;
  logic [31:0] s_mem_addr, s_mem_wdata, s_rsp_data;
  logic [2:0]  s_mem_funct3;
  logic [3:0]  s_load_count, s_store_count;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0, rd_pulses = 0, rv_cycles = 0;
  logic [2:0] last_wr_f3 = 3'b111;
  int wr0, rd0, rv0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .load_count(load_count), .store_count(store_count)
  );

  load_store_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_funct3(s_mem_funct3),
    .mem_rdata(mem_rdata), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy),
    .load_count(s_load_count), .store_count(s_store_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Strobe and response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write) begin
      wr_pulses++;
      last_wr_f3 = mem_funct3;
    end
    if (mem_read) rd_pulses++;
    if (rsp_valid) rv_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be accepted on the next edge.
  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    step();
    req_valid  = 1'b0;
  endtask

  // Load with a given memory word; returns the response seen in RESP.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                         output logic [31:0] data);
    send(1'b0, f3, a, 32'h0);
    mem_rdata = w;
    step();
    data = rsp_data;
    step();
    mem_rdata = 32'h0;
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; rsp_ready = 1'b1;
    repeat (2) step();

    // Reset values, checked while reset is still asserted.
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_counts", {load_count, store_count}, 32'h0);
    rst = 1'b0;
    step();

    // lw at 0x10: ISSUE one cycle after accept, data one edge later.
    send(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_issue_read", {31'b0, mem_read}, 32'h1);
    check("lw_issue_addr", mem_addr, 32'h10);
    check("lw_issue_f3", {29'b0, mem_funct3}, 32'h2);
    check("lw_busy", {30'b0, busy, req_ready}, 32'h2);
    mem_rdata = 32'hDEADBEEF;
    step();
    check("lw_rsp_valid", {30'b0, rsp_valid, rsp_err}, 32'h2);
    check("lw_rsp_data", rsp_data, 32'hDEADBEEF);
    check("lw_strobe_off", {31'b0, mem_read}, 32'h0);
    step();
    mem_rdata = 32'h0;
    check("lw_load_count", {16'b0, load_count}, 32'h1);
    check("lw_idle", {30'b0, req_ready, rsp_valid}, 32'h2);

    // Sign vs zero extension.
    do_load(3'b000, 32'h04, 32'h00000080, got);
    check("lb_sext", got, 32'hFFFFFF80);
    do_load(3'b100, 32'h04, 32'h00000080, got);
    check("lbu_zext", got, 32'h00000080);
    do_load(3'b001, 32'h06, 32'h12348001, got);
    check("lh_sext", got, 32'hFFFF8001);
    do_load(3'b101, 32'h06, 32'h12348001, got);
    check("lhu_zext", got, 32'h00008001);
    // Highest legal byte and word addresses.
    do_load(3'b000, 32'h7F, 32'h0000007F, got);
    check("lb_top_byte", got, 32'h0000007F);
    do_load(3'b010, 32'h7C, 32'hCAFEF00D, got);
    check("lw_top_word", got, 32'hCAFEF00D);
    check("load_count_7", {16'b0, load_count}, 32'h7);

    // sw with write-back stalled for 5 cycles: exactly one write strobe.
    rsp_ready = 1'b0;
    wr0 = wr_pulses;
    send(1'b1, 3'b010, 32'h0C, 32'h12345678);
    check("sw_issue", {30'b0, mem_write, mem_read}, 32'h2);
    check("sw_wdata", mem_wdata, 32'h12345678);
    check("sw_addr", mem_addr, 32'h0C);
    step();
    repeat (5) step();
    check("sw_stall_state", {29'b0, rsp_valid, req_ready, busy}, 32'h5);
    check("sw_rsp_data", rsp_data, 32'h0);
    check("sw_one_strobe", wr_pulses - wr0, 32'h1);
    check("sw_strobe_f3", {29'b0, last_wr_f3}, 32'h2);
    check("sw_count_pending", {16'b0, store_count}, 32'h0);
    rsp_ready = 1'b1;
    step();
    check("sw_store_count", {16'b0, store_count}, 32'h1);

    // Illegal accesses: response one edge after accept, no strobes.
    wr0 = wr_pulses; rd0 = rd_pulses;
    send(1'b0, 3'b001, 32'h03, 32'h0);
    check("lh_mis_err", {29'b0, rsp_valid, rsp_err, mem_read}, 32'h6);
    check("lh_mis_data", rsp_data, 32'h0);
    step();
    send(1'b1, 3'b010, 32'h7E, 32'hFFFFFFFF);
    check("sw_7e_err", {29'b0, rsp_valid, rsp_err, mem_write}, 32'h6);
    step();
    send(1'b0, 3'b010, 32'h80, 32'h0);
    check("lw_80_err", {29'b0, rsp_valid, rsp_err, mem_read}, 32'h6);
    step();
    send(1'b1, 3'b100, 32'h00, 32'h0);
    check("sbu_f3_err", {30'b0, rsp_valid, rsp_err}, 32'h3);
    step();
    send(1'b0, 3'b000, 32'h80, 32'h0);
    check("lb_80_err", {30'b0, rsp_valid, rsp_err}, 32'h3);
    step();
    check("err_no_strobes", (wr_pulses - wr0) + (rd_pulses - rd0), 32'h0);
    check("err_counts", {load_count, store_count}, 32'h00070001);

    // Reset during ISSUE of a load: outputs drop without an edge.
    rv0 = rv_cycles;
    send(1'b0, 3'b010, 32'h20, 32'h0);
    check("rst_pre_read", {31'b0, mem_read}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", {28'b0, mem_read, rsp_valid, busy, req_ready}, 32'h1);
    check("rst_async_cnt", {load_count, store_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    check("rst_no_rsp", rv_cycles - rv0, 32'h0);

    // Stores toward saturation of the 4-bit counter instance.
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 3'b000, 32'(i), 32'(i));
      step();
      step();
    end
    check("sat_at_max", {28'b0, s_store_count}, 32'hF);
    check("main_15", {16'b0, store_count}, 32'hF);
    send(1'b1, 3'b000, 32'h40, 32'h0);
    step();
    step();
    check("sat_hold", {28'b0, s_store_count}, 32'hF);
    check("main_16", {16'b0, store_count}, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
